// File: rtl/mrdo_video_timing.sv
// rtl/mrdo_video_timing.sv - Mr. Do raster timing: pixel/line counters, blanking, syncs, strobes
module mrdo_video_timing #(
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 192,
    parameter int VS_START = 216,
    parameter int VS_END   = 219
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       ce_pix,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       hblank,
    output logic       vblank,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       line_start,
    output logic       vblank_start,
    output logic [7:0] frame_cnt
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    // Ten-bit thresholds so an end value of 512 does not alias to zero.
    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] HS_S  = 10'(HS_START);
    localparam logic [9:0] HS_E  = 10'(HS_END);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] VS_S  = 10'(VS_START);
    localparam logic [9:0] VS_E  = 10'(VS_END);

    logic       h_wrap;
    logic       v_wrap;
    logic [8:0] h_nxt;
    logic [8:0] v_nxt;
    logic [9:0] h_nxt_w;
    logic [9:0] v_nxt_w;

    always_comb begin
        h_wrap = (hcnt == H_LAST);
        v_wrap = (vcnt == V_LAST);
        h_nxt  = h_wrap ? 9'd0 : hcnt + 9'd1;
        v_nxt  = vcnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? 9'd0 : vcnt + 9'd1;
        end
        h_nxt_w = {1'b0, h_nxt};
        v_nxt_w = {1'b0, v_nxt};
    end

    // Levels are decoded from the next counts so they line up with the counters they accompany.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            hcnt         <= 9'd0;
            vcnt         <= 9'd0;
            frame_cnt    <= 8'd0;
            hblank       <= 1'b0;
            vblank       <= 1'b0;
            hsync_n      <= 1'b1;
            vsync_n      <= 1'b1;
            line_start   <= 1'b0;
            vblank_start <= 1'b0;
        end else if (ce_pix) begin
            hcnt         <= h_nxt;
            vcnt         <= v_nxt;
            if (h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            hblank       <= (h_nxt_w >= H_ACT);
            vblank       <= (v_nxt_w >= V_ACT);
            hsync_n      <= !((h_nxt_w >= HS_S) && (h_nxt_w < HS_E));
            vsync_n      <= !((v_nxt_w >= VS_S) && (v_nxt_w < VS_E));
            line_start   <= h_wrap;
            vblank_start <= h_wrap && (v_nxt_w == V_ACT);
        end else begin
            line_start   <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mrdo_video_timing.sv
// tb/tb_mrdo_video_timing.sv - randomized bench for mrdo_video_timing with pixel-index reference model
module tb_mrdo_video_timing;

    localparam int HT  [2] = '{384, 24};
    localparam int HA  [2] = '{256, 16};
    localparam int HSS [2] = '{288, 18};
    localparam int HSE [2] = '{320, 20};
    localparam int VT  [2] = '{264, 16};
    localparam int VA  [2] = '{192, 10};
    localparam int VSS [2] = '{216, 12};
    localparam int VSE [2] = '{219, 15};

    logic       clk = 1'b0;
    logic [1:0] clr = 2'b00;
    logic [1:0] ce  = 2'b00;
    logic [8:0] hcnt [2];
    logic [8:0] vcnt [2];
    logic [7:0] frame_cnt [2];
    logic       hblank [2];
    logic       vblank [2];
    logic       hsync_n [2];
    logic       vsync_n [2];
    logic       line_start [2];
    logic       vblank_start [2];

    int checks = 0;
    int errors = 0;

    longint p [2];
    bit     adv [2];
    bit     valid [2];

    int cnt_ls [2];
    int cnt_vbs [2];
    int cnt_hb [2];
    int cnt_hs [2];
    int cnt_vs [2];

    always #5 clk = ~clk;

    mrdo_video_timing u_dflt (
        .clk(clk), .clear_n(clr[0]), .ce_pix(ce[0]),
        .hcnt(hcnt[0]), .vcnt(vcnt[0]), .hblank(hblank[0]), .vblank(vblank[0]),
        .hsync_n(hsync_n[0]), .vsync_n(vsync_n[0]), .line_start(line_start[0]),
        .vblank_start(vblank_start[0]), .frame_cnt(frame_cnt[0])
    );

    mrdo_video_timing #(
        .H_TOTAL(24), .H_ACTIVE(16), .HS_START(18), .HS_END(20),
        .V_TOTAL(16), .V_ACTIVE(10), .VS_START(12), .VS_END(15)
    ) u_small (
        .clk(clk), .clear_n(clr[1]), .ce_pix(ce[1]),
        .hcnt(hcnt[1]), .vcnt(vcnt[1]), .hblank(hblank[1]), .vblank(vblank[1]),
        .hsync_n(hsync_n[1]), .vsync_n(vsync_n[1]), .line_start(line_start[1]),
        .vblank_start(vblank_start[1]), .frame_cnt(frame_cnt[1])
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the raster position is just the number of pixels advanced since reset.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b1;
            if (!clr[i]) begin
                p[i]   = 0;
                adv[i] = 1'b0;
            end else if (ce[i]) begin
                p[i]   = p[i] + 1;
                adv[i] = 1'b1;
            end else begin
                adv[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (valid[i]) begin
                longint h, v, f;
                logic [31:0] e, a;
                h = p[i] % HT[i];
                v = (p[i] / HT[i]) % VT[i];
                f = (p[i] / (HT[i] * VT[i])) % 256;
                e = {9'(h), 9'(v), 8'(f), h >= HA[i], v >= VA[i],
                     !(h >= HSS[i] && h < HSE[i]), !(v >= VSS[i] && v < VSE[i]),
                     adv[i] && h == 0, adv[i] && h == 0 && v == VA[i]};
                a = {hcnt[i], vcnt[i], frame_cnt[i], hblank[i], vblank[i],
                     hsync_n[i], vsync_n[i], line_start[i], vblank_start[i]};
                chk($sformatf("inst%0d outputs", i), a, e);
            end
        end
    end

    task automatic clear_cnt(input int i);
        cnt_ls[i] = 0; cnt_vbs[i] = 0; cnt_hb[i] = 0; cnt_hs[i] = 0; cnt_vs[i] = 0;
    endtask

    task automatic step(input int i, input bit c);
        @(negedge clk);
        ce[i] = c;
        @(posedge clk);
        #1;
        if (line_start[i]) cnt_ls[i]++;
        if (vblank_start[i]) cnt_vbs[i]++;
        if (c) begin
            if (hblank[i]) cnt_hb[i]++;
            if (!hsync_n[i]) cnt_hs[i]++;
            if (hcnt[i] == 9'd0 && !vsync_n[i]) cnt_vs[i]++;
        end
    endtask

    task automatic do_reset(input int i);
        @(negedge clk);
        clr[i] = 1'b0;
        ce[i]  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr[i] = 1'b1;
    endtask

    initial begin
        fork
            begin : run_default
                do_reset(0);
                clear_cnt(0);
                repeat (10) step(0, 1'b0);
                chk("idle hcnt", hcnt[0], 0);
                chk("idle vcnt", vcnt[0], 0);
                chk("idle syncs", {hsync_n[0], vsync_n[0]}, 2'b11);
                chk("idle strobes", cnt_ls[0] + cnt_vbs[0], 0);
                clear_cnt(0);
                repeat (384) begin
                    step(0, 1'b1);
                    repeat (3) step(0, 1'b0);
                end
                chk("line wrap hcnt", hcnt[0], 0);
                chk("line wrap vcnt", vcnt[0], 1);
                chk("line_start pulses", cnt_ls[0], 1);
                chk("hblank pixels", cnt_hb[0], 128);
                chk("hsync pixels", cnt_hs[0], 32);
                repeat (150 * 384 + 100 - 384) step(0, 1'b1);
                chk("pre-reset hcnt", hcnt[0], 100);
                chk("pre-reset vcnt", vcnt[0], 150);
                @(negedge clk);
                clr[0] = 1'b0;
                ce[0]  = 1'b1;
                @(posedge clk);
                #1;
                chk("mid reset counters", {hcnt[0], vcnt[0], frame_cnt[0]}, 0);
                chk("mid reset strobes", {line_start[0], vblank_start[0]}, 0);
                @(negedge clk);
                clr[0] = 1'b1;
                ce[0]  = 1'b0;
                step(0, 1'b0);
                step(0, 1'b1);
                chk("resume hcnt", hcnt[0], 1);
                chk("resume vcnt", vcnt[0], 0);
            end
            begin : run_small
                do_reset(1);
                clear_cnt(1);
                repeat (2 * 384) step(1, 1'b1);
                chk("two frames frame_cnt", frame_cnt[1], 2);
                chk("two frames vblank_start", cnt_vbs[1], 2);
                chk("two frames line_start", cnt_ls[1], 32);
                clear_cnt(1);
                for (int px = 0; px < 3 * 384; ) begin
                    bit c;
                    c = 1'($urandom_range(0, 1));
                    step(1, c);
                    if (c) px++;
                end
                chk("random frame_cnt", frame_cnt[1], 5);
                chk("random vblank_start", cnt_vbs[1], 3);
                chk("random vsync lines", cnt_vs[1], 9);
                chk("random line_start", cnt_ls[1], 48);
                chk("frame end position", {hcnt[1], vcnt[1], vblank[1]}, 0);
            end
        join
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
